// File: rtl/wrapper_pkg.sv
// Shared definitions for the core test wrapper: instruction width, opcodes,
// and the data-register selection decode.
package wrapper_pkg;

  localparam int WIR_W = 3;

  localparam logic [WIR_W-1:0] OP_BYPASS = 3'b000;
  localparam logic [WIR_W-1:0] OP_EXTEST = 3'b001;
  localparam logic [WIR_W-1:0] OP_INTEST = 3'b010;
  localparam logic [WIR_W-1:0] OP_SAFE   = 3'b011;

  // Data register placed between wsi and wso when select_wir is low
  typedef enum logic {
    SEL_WBY = 1'b0,
    SEL_WBR = 1'b1
  } dr_sel_e;

  // EXTEST/INTEST use the boundary register; every other code, including
  // unassigned ones, behaves as BYPASS and uses the 1-bit bypass register.
  function automatic dr_sel_e decode_dr(input logic [WIR_W-1:0] instr);
    case (instr)
      OP_EXTEST, OP_INTEST: return SEL_WBR;
      default:              return SEL_WBY;
    endcase
  endfunction

endpackage

// File: rtl/wbr_cell.sv
// One wrapper boundary cell: a shift stage that captures or shifts, and an
// update stage that holds the value presented to the functional path.
module wbr_cell (
  input  logic clk,
  input  logic reset,
  input  logic capture_en,
  input  logic shift_en,
  input  logic update_en,
  input  logic capture_d,
  input  logic scan_in,
  output logic shift_q,
  output logic update_q
);

  // Capture beats shift; update copies the pre-edge shift stage in parallel
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      if (capture_en) begin
        shift_q <= capture_d;
      end else if (shift_en) begin
        shift_q <= scan_in;
      end
      if (update_en) begin
        update_q <= shift_q;
      end
    end
  end

endmodule

// File: rtl/wrapper_boundary_ctrl.sv
// Parametrised core test wrapper: WIR instruction register, 1-bit bypass
// register and an N_IN+N_OUT boundary register between pins and core.
// Chain order: wsi -> cell 0 .. cell N_IN-1 (inputs) -> cell N_IN .. N-1
// (outputs) -> wso.
module wrapper_boundary_ctrl
  import wrapper_pkg::*;
#(
  parameter int               N_IN     = 4,
  parameter int               N_OUT    = 4,
  parameter logic [N_OUT-1:0] SAFE_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wsi,
  output logic             wso,
  input  logic             select_wir,
  input  logic             capture_wr,
  input  logic             shift_wr,
  input  logic             update_wr,
  input  logic [N_IN-1:0]  pi,
  output logic [N_IN-1:0]  ci_to_core,
  input  logic [N_OUT-1:0] co_from_core,
  output logic [N_OUT-1:0] po,
  output logic [WIR_W-1:0] active_instr
);

  localparam int N = N_IN + N_OUT;

  logic [WIR_W-1:0] wir_shift;
  logic             wby;
  dr_sel_e          dr_sel;
  logic             wbr_en;
  logic             wby_en;
  logic [N-1:0]     cap_d;
  logic [N-1:0]     scan_in;
  logic [N-1:0]     sh_q;
  logic [N-1:0]     up_q;

  assign dr_sel = decode_dr(active_instr);
  assign wbr_en = !select_wir && (dr_sel == SEL_WBR);
  assign wby_en = !select_wir && (dr_sel == SEL_WBY);

  // Each cell shifts from its lower neighbour; cell 0 takes wsi
  assign scan_in = {sh_q[N-2:0], wsi};

  // INTEST observes the core side of the cells, EXTEST the pin side
  assign cap_d = (active_instr == OP_INTEST) ? {co_from_core, ci_to_core}
                                             : {po, pi};

  for (genvar i = 0; i < N; i++) begin : g_cell
    wbr_cell u_cell (
      .clk        (clk),
      .reset      (reset),
      .capture_en (wbr_en && capture_wr),
      .shift_en   (wbr_en && shift_wr),
      .update_en  (wbr_en && update_wr),
      .capture_d  (cap_d[i]),
      .scan_in    (scan_in[i]),
      .shift_q    (sh_q[i]),
      .update_q   (up_q[i])
    );
  end

  // WIR: capture reads back the active instruction, update makes the shifted
  // code active from the next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wir_shift    <= '0;
      active_instr <= OP_BYPASS;
    end else if (select_wir) begin
      if (capture_wr) begin
        wir_shift <= active_instr;
      end else if (shift_wr) begin
        wir_shift <= {wir_shift[WIR_W-2:0], wsi};
      end
      if (update_wr) begin
        active_instr <= wir_shift;
      end
    end
  end

  // WBY: capture clears it, shift gives a single-cycle wsi -> wso path
  always_ff @(posedge clk) begin
    if (reset) begin
      wby <= 1'b0;
    end else if (wby_en) begin
      if (capture_wr) begin
        wby <= 1'b0;
      end else if (shift_wr) begin
        wby <= wsi;
      end
    end
  end

  // Scan-out selects the last bit of whichever register is targeted
  always_comb begin
    wso = wby;
    if (select_wir) begin
      wso = wir_shift[WIR_W-1];
    end else if (dr_sel == SEL_WBR) begin
      wso = sh_q[N-1];
    end
  end

  // Functional path muxing by instruction; unknown codes pass through
  always_comb begin
    ci_to_core = pi;
    po         = co_from_core;
    case (active_instr)
      OP_EXTEST: po = up_q[N-1:N_IN];
      OP_INTEST: begin
        ci_to_core = up_q[N_IN-1:0];
        po         = SAFE_VAL;
      end
      OP_SAFE:   po = SAFE_VAL;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_wrapper_boundary_ctrl.sv
// Directed bench for wrapper_boundary_ctrl with 4 input and 4 output cells
// and SAFE_VAL = 4'hF. Inputs change after the falling edge; outputs are
// sampled after the falling edge following each rising edge.
module tb_wrapper_boundary_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       wsi;
  logic       wso;
  logic       select_wir;
  logic       capture_wr;
  logic       shift_wr;
  logic       update_wr;
  logic [3:0] pi;
  logic [3:0] ci_to_core;
  logic [3:0] co_from_core;
  logic [3:0] po;
  logic [2:0] active_instr;

  int vec_cnt = 0;
  int err_cnt = 0;

  wrapper_boundary_ctrl #(
    .N_IN     (4),
    .N_OUT    (4),
    .SAFE_VAL (4'hF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wsi          (wsi),
    .wso          (wso),
    .select_wir   (select_wir),
    .capture_wr   (capture_wr),
    .shift_wr     (shift_wr),
    .update_wr    (update_wr),
    .pi           (pi),
    .ci_to_core   (ci_to_core),
    .co_from_core (co_from_core),
    .po           (po),
    .active_instr (active_instr)
  );

  // Clock and cycle budget
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL timeout: run did not complete within 20000 time units");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic shift_wir(input logic [2:0] code);
    select_wir = 1'b1;
    shift_wr   = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      wsi = code[i];
      step();
    end
    shift_wr = 1'b0;
    wsi      = 1'b0;
  endtask

  task automatic do_update(input logic sel);
    select_wir = sel;
    update_wr  = 1'b1;
    step();
    update_wr  = 1'b0;
  endtask

  task automatic load_instr(input logic [2:0] code);
    shift_wir(code);
    do_update(1'b1);
    select_wir = 1'b0;
  endtask

  task automatic shift_dr(input logic [7:0] v);
    select_wir = 1'b0;
    shift_wr   = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wsi = v[i];
      step();
    end
    shift_wr = 1'b0;
    wsi      = 1'b0;
  endtask

  task automatic do_capture(input logic sel);
    select_wir = sel;
    capture_wr = 1'b1;
    step();
    capture_wr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; pi = 4'h6; co_from_core = 4'h9;
    step(); step();
    reset = 1'b0;
    step();
    vec_cnt++; if (active_instr !== 3'b000) begin err_cnt++; $display("FAIL reset_instr: got %h want 0", active_instr); end
    vec_cnt++; if (ci_to_core !== 4'h6) begin err_cnt++; $display("FAIL reset_ci: got %h want 6", ci_to_core); end
    vec_cnt++; if (po !== 4'h9) begin err_cnt++; $display("FAIL reset_po: got %h want 9", po); end
    vec_cnt++; if (wso !== 1'b0) begin err_cnt++; $display("FAIL reset_wso: got %b want 0", wso); end
  endtask

  task automatic test_wir_load();
    shift_wir(3'b001);
    vec_cnt++; if (active_instr !== 3'b000) begin err_cnt++; $display("FAIL wir_pre_update: got %h want 0", active_instr); end
    do_update(1'b1);
    select_wir = 1'b0;
    vec_cnt++; if (active_instr !== 3'b001) begin err_cnt++; $display("FAIL wir_update: got %h want 1", active_instr); end
    vec_cnt++; if (po !== 4'h0) begin err_cnt++; $display("FAIL extest_po_init: got %h want 0", po); end
  endtask

  task automatic test_extest_update();
    shift_dr(8'hA5);
    vec_cnt++; if (po !== 4'h0) begin err_cnt++; $display("FAIL extest_po_pre_update: got %h want 0", po); end
    do_update(1'b0);
    vec_cnt++; if (po !== 4'hA) begin err_cnt++; $display("FAIL extest_po: got %h want A", po); end
    vec_cnt++; if (ci_to_core !== 4'h6) begin err_cnt++; $display("FAIL extest_ci: got %h want 6", ci_to_core); end
    pi = 4'hC;
    #1;
    vec_cnt++; if (ci_to_core !== 4'hC) begin err_cnt++; $display("FAIL extest_ci_follow: got %h want C", ci_to_core); end
  endtask

  task automatic test_extest_capture();
    logic [7:0] exp_v;
    exp_v = 8'hA3;
    pi = 4'h3;
    do_capture(1'b0);
    shift_wr = 1'b1;
    wsi      = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      vec_cnt++;
      if (wso !== exp_v[i]) begin err_cnt++; $display("FAIL extest_capture_bit%0d: got %b want %b", i, wso, exp_v[i]); end
      step();
    end
    shift_wr = 1'b0;
  endtask

  task automatic test_bypass_safe();
    logic [2:0] exp_wir;
    logic [2:0] pat;
    // WIR capture reads back the active instruction (EXTEST) MSB first
    exp_wir = 3'b001;
    do_capture(1'b1);
    shift_wr = 1'b1;
    wsi      = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      vec_cnt++;
      if (wso !== exp_wir[i]) begin err_cnt++; $display("FAIL wir_capture_bit%0d: got %b want %b", i, wso, exp_wir[i]); end
      step();
    end
    shift_wr = 1'b0;
    do_update(1'b1);
    select_wir = 1'b0;
    vec_cnt++; if (active_instr !== 3'b000) begin err_cnt++; $display("FAIL bypass_instr: got %h want 0", active_instr); end
    pi = 4'h6; co_from_core = 4'h9;
    #1;
    vec_cnt++; if (po !== 4'h9) begin err_cnt++; $display("FAIL bypass_po: got %h want 9", po); end
    // Single-cycle bypass path
    pat = 3'b101;
    shift_wr = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      wsi = pat[i];
      step();
      vec_cnt++;
      if (wso !== pat[i]) begin err_cnt++; $display("FAIL bypass_shift%0d: got %b want %b", i, wso, pat[i]); end
    end
    shift_wr = 1'b0;
    wsi      = 1'b0;
    // Bypass capture clears the register, update on WBY does nothing
    do_capture(1'b0);
    vec_cnt++; if (wso !== 1'b0) begin err_cnt++; $display("FAIL bypass_capture: got %b want 0", wso); end
    // SAFE drives SAFE_VAL on the pins
    load_instr(3'b011);
    vec_cnt++; if (po !== 4'hF) begin err_cnt++; $display("FAIL safe_po: got %h want F", po); end
    vec_cnt++; if (ci_to_core !== 4'h6) begin err_cnt++; $display("FAIL safe_ci: got %h want 6", ci_to_core); end
    // An unassigned code behaves as BYPASS
    load_instr(3'b101);
    vec_cnt++; if (po !== 4'h9) begin err_cnt++; $display("FAIL unknown_po: got %h want 9", po); end
  endtask

  task automatic test_intest();
    logic [7:0] exp_v;
    load_instr(3'b010);
    // Update stages still hold A5 from EXTEST
    vec_cnt++; if (ci_to_core !== 4'h5) begin err_cnt++; $display("FAIL intest_ci_retained: got %h want 5", ci_to_core); end
    vec_cnt++; if (po !== 4'hF) begin err_cnt++; $display("FAIL intest_po: got %h want F", po); end
    shift_dr(8'h0C);
    do_update(1'b0);
    vec_cnt++; if (ci_to_core !== 4'hC) begin err_cnt++; $display("FAIL intest_ci: got %h want C", ci_to_core); end
    co_from_core = 4'h5;
    do_capture(1'b0);
    exp_v = 8'h5C;
    shift_wr = 1'b1;
    wsi      = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      vec_cnt++;
      if (wso !== exp_v[i]) begin err_cnt++; $display("FAIL intest_capture_bit%0d: got %b want %b", i, wso, exp_v[i]); end
      step();
    end
    shift_wr = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    shift_dr(8'hFF);
    do_update(1'b0);
    select_wir = 1'b0;
    shift_wr   = 1'b1;
    wsi        = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset    = 1'b0;
    shift_wr = 1'b0;
    wsi      = 1'b0;
    pi = 4'h2; co_from_core = 4'h7;
    #1;
    vec_cnt++; if (active_instr !== 3'b000) begin err_cnt++; $display("FAIL midrst_instr: got %h want 0", active_instr); end
    vec_cnt++; if (po !== 4'h7) begin err_cnt++; $display("FAIL midrst_po: got %h want 7", po); end
    vec_cnt++; if (ci_to_core !== 4'h2) begin err_cnt++; $display("FAIL midrst_ci: got %h want 2", ci_to_core); end
    vec_cnt++; if (wso !== 1'b0) begin err_cnt++; $display("FAIL midrst_wso: got %b want 0", wso); end
    load_instr(3'b001);
    vec_cnt++; if (po !== 4'h0) begin err_cnt++; $display("FAIL midrst_out_cells: got %h want 0", po); end
    vec_cnt++; if (wso !== 1'b0) begin err_cnt++; $display("FAIL midrst_chain_tail: got %b want 0", wso); end
    load_instr(3'b010);
    vec_cnt++; if (ci_to_core !== 4'h0) begin err_cnt++; $display("FAIL midrst_in_cells: got %h want 0", ci_to_core); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; wsi = 1'b0; select_wir = 1'b0;
    capture_wr = 1'b0; shift_wr = 1'b0; update_wr = 1'b0;
    pi = 4'h0; co_from_core = 4'h0;
    @(negedge clk);
    test_reset();
    test_wir_load();
    test_extest_update();
    test_extest_capture();
    test_bypass_safe();
    test_intest();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
